// File: rtl/tx_lane_scheduler.sv
// Transmit lane scheduler: merges sync (priority) and async (round-robin) FWFT
// word streams into one 9-bit symbol per SLOT_CYCLES-clock slot.
module tx_lane_scheduler #(
  parameter int          N_CH           = 2,
  parameter int          SLOT_CYCLES    = 5,
  parameter int          SYNC_HOLD      = 2,
  parameter int          ASYNC_HOLD     = 8,
  parameter logic [8:0]  K_IDLE         = 9'h1BC,
  parameter logic [8:0]  TIMESTAMP_CODE = 9'h000,
  localparam int         CHW            = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              enable_i,
  input  logic [N_CH-1:0]   sync_valid_i,
  input  logic [9*N_CH-1:0] sync_data_i,
  output logic [N_CH-1:0]   sync_rd_o,
  input  logic [N_CH-1:0]   async_valid_i,
  input  logic [9*N_CH-1:0] async_data_i,
  output logic [N_CH-1:0]   async_rd_o,
  output logic [8:0]        sym_o,
  output logic              sym_stb_o,
  output logic              timestamp_code_o,
  output logic              owner_class_o,
  output logic [CHW-1:0]    owner_ch_o,
  output logic              idle_o
);

  localparam logic [0:0] CLS_ASYNC = 1'b0;
  localparam logic [0:0] CLS_SYNC  = 1'b1;

  localparam int CW   = $clog2(SLOT_CYCLES);
  localparam int HMAX = (SYNC_HOLD > ASYNC_HOLD) ? SYNC_HOLD : ASYNC_HOLD;
  localparam int HW   = (HMAX > 0) ? $clog2(HMAX + 1) : 1;

  logic [CW-1:0]  slot_cnt;
  logic [0:0]     owner_class;
  logic [CHW-1:0] owner_ch;
  logic [CHW-1:0] last_async;
  logic [HW-1:0]  hold;

  logic [0:0]     nxt_class;
  logic [CHW-1:0] nxt_ch;
  logic [CHW-1:0] nxt_last;
  logic [HW-1:0]  nxt_hold;
  logic           pop;
  logic           pop_sync;
  logic [CHW-1:0] pop_ch;
  logic [CHW-1:0] sync_low;
  logic           sync_any;
  logic           rr_any;
  logic [CHW-1:0] rr_ch;
  logic           boundary;
  logic           do_pop;
  logic [8:0]     pop_data;

  always_comb begin
    sync_any = |sync_valid_i;
    sync_low = '0;
    for (int unsigned k = N_CH; k > 0; k--)
      if (sync_valid_i[k-1]) sync_low = CHW'(k - 1);

    // Scan from the farthest candidate to the nearest so a+1 wins and a is last.
    rr_any = 1'b0;
    rr_ch  = owner_ch;
    for (int unsigned i = N_CH; i >= 1; i--) begin
      if (async_valid_i[(i + 32'(owner_ch)) % N_CH]) begin
        rr_any = 1'b1;
        rr_ch  = CHW'((i + 32'(owner_ch)) % N_CH);
      end
    end

    nxt_class = owner_class;
    nxt_ch    = owner_ch;
    nxt_last  = last_async;
    nxt_hold  = hold;
    pop       = 1'b0;
    pop_sync  = 1'b0;
    pop_ch    = '0;

    if (owner_class == CLS_SYNC) begin
      if (sync_valid_i[owner_ch]) begin
        pop = 1'b1; pop_sync = 1'b1; pop_ch = owner_ch; nxt_hold = '0;
      end else if (hold < HW'(SYNC_HOLD)) begin
        nxt_hold = hold + HW'(1);
      end else if (sync_any) begin
        nxt_ch = sync_low; pop = 1'b1; pop_sync = 1'b1; pop_ch = sync_low; nxt_hold = '0;
      end else begin
        nxt_class = CLS_ASYNC; nxt_ch = last_async; nxt_hold = '0;
      end
    end else begin
      if (sync_any) begin
        nxt_class = CLS_SYNC; nxt_ch = sync_low; nxt_last = owner_ch;
        pop = 1'b1; pop_sync = 1'b1; pop_ch = sync_low; nxt_hold = '0;
      end else if (async_valid_i[owner_ch]) begin
        pop = 1'b1; pop_ch = owner_ch; nxt_hold = '0;
      end else if (hold < HW'(ASYNC_HOLD)) begin
        nxt_hold = hold + HW'(1);
      end else if (rr_any) begin
        nxt_ch = rr_ch; pop = 1'b1; pop_ch = rr_ch; nxt_hold = '0;
      end
    end
  end

  assign boundary = (slot_cnt == '0);
  assign do_pop   = boundary && enable_i && pop;
  assign pop_data = pop_sync ? sync_data_i[9*pop_ch +: 9] : async_data_i[9*pop_ch +: 9];

  // Pops are gated by reset so no FIFO is drained while the counter sits at 0 in reset.
  assign sync_rd_o  = (rst_n_i && do_pop && pop_sync)  ? (N_CH'(1) << pop_ch) : '0;
  assign async_rd_o = (rst_n_i && do_pop && !pop_sync) ? (N_CH'(1) << pop_ch) : '0;

  assign owner_class_o = owner_class;
  assign owner_ch_o    = owner_ch;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      slot_cnt         <= '0;
      owner_class      <= CLS_ASYNC;
      owner_ch         <= '0;
      last_async       <= '0;
      hold             <= '0;
      sym_o            <= K_IDLE;
      sym_stb_o        <= 1'b0;
      timestamp_code_o <= 1'b0;
      idle_o           <= 1'b1;
    end else begin
      slot_cnt <= (slot_cnt == CW'(SLOT_CYCLES - 1)) ? '0 : slot_cnt + CW'(1);
      if (boundary) begin
        sym_stb_o <= 1'b1;
        if (do_pop) begin
          sym_o            <= pop_data;
          idle_o           <= 1'b0;
          timestamp_code_o <= (pop_data == TIMESTAMP_CODE);
        end else begin
          sym_o            <= K_IDLE;
          idle_o           <= 1'b1;
          timestamp_code_o <= 1'b0;
        end
        if (enable_i) begin
          owner_class <= nxt_class;
          owner_ch    <= nxt_ch;
          last_async  <= nxt_last;
          hold        <= nxt_hold;
        end
      end else begin
        sym_stb_o        <= 1'b0;
        timestamp_code_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// Bench for tx_lane_scheduler: bench-side FIFO queues feed the DUT and a
// slot-level reference model predicts pops and emitted symbols.
module tb_tx_lane_scheduler;
  localparam int N    = 2;
  localparam int SLOT = 5;
  localparam int SH   = 2;
  localparam int AH   = 8;
  localparam int CHW  = 1;
  localparam logic [8:0] KI = 9'h1BC;
  localparam logic [8:0] TS = 9'h000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic [N-1:0]   sync_valid = '0, async_valid = '0;
  logic [9*N-1:0] sync_data = '0, async_data = '0;
  logic [N-1:0]   sync_rd, async_rd;
  logic [8:0]     sym;
  logic           stb, ts_o, ocls, idle;
  logic [CHW-1:0] och;

  tx_lane_scheduler #(.N_CH(N), .SLOT_CYCLES(SLOT), .SYNC_HOLD(SH), .ASYNC_HOLD(AH),
                      .K_IDLE(KI), .TIMESTAMP_CODE(TS)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(en),
    .sync_valid_i(sync_valid), .sync_data_i(sync_data), .sync_rd_o(sync_rd),
    .async_valid_i(async_valid), .async_data_i(async_data), .async_rd_o(async_rd),
    .sym_o(sym), .sym_stb_o(stb), .timestamp_code_o(ts_o),
    .owner_class_o(ocls), .owner_ch_o(och), .idle_o(idle));

  always #5 clk = ~clk;

  logic [8:0] sq[N][$];
  logic [8:0] aq[N][$];
  logic [N-1:0] smask = '0, amask = '0;

  // reference model state: owner is (class, channel), plus hold and remembered async owner
  bit m_cls; int m_ch, m_hold, m_last;
  logic [8:0] m_sym; bit m_idle;
  int phase;
  int total = 0, bad = 0;

  logic [N-1:0] obs_srd, obs_ard, exp_srd, exp_ard;
  logic [8:0] obs_sym; logic obs_stb, obs_ts, obs_ocls, obs_idle; logic [CHW-1:0] obs_och;
  bit exp_stb, exp_ts;
  bit last_pop; logic [8:0] last_word;

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      sync_valid[k] = (sq[k].size() > 0) && !smask[k];
      sync_data[9*k +: 9] = (sq[k].size() > 0) ? sq[k][0] : 9'($urandom);
      async_valid[k] = (aq[k].size() > 0) && !amask[k];
      async_data[9*k +: 9] = (aq[k].size() > 0) ? aq[k][0] : 9'($urandom);
    end
  endtask

  task automatic m_decide(output bit pop, output bit ps, output int pc);
    int lo = -1;
    for (int k = N - 1; k >= 0; k--) if (sync_valid[k]) lo = k;
    pop = 0; ps = 0; pc = 0;
    if (m_cls) begin
      if (sync_valid[m_ch]) begin pop = 1; ps = 1; pc = m_ch; m_hold = 0; end
      else if (m_hold < SH) m_hold++;
      else if (lo >= 0) begin m_ch = lo; pop = 1; ps = 1; pc = lo; m_hold = 0; end
      else begin m_cls = 0; m_ch = m_last; m_hold = 0; end
    end else begin
      if (lo >= 0) begin m_last = m_ch; m_cls = 1; m_ch = lo; pop = 1; ps = 1; pc = lo; m_hold = 0; end
      else if (async_valid[m_ch]) begin pop = 1; pc = m_ch; m_hold = 0; end
      else if (m_hold < AH) m_hold++;
      else begin
        for (int i = 1; i <= N; i++)
          if (!pop && async_valid[(m_ch + i) % N]) begin pop = 1; pc = (m_ch + i) % N; end
        if (pop) begin m_ch = pc; m_hold = 0; end
      end
    end
  endtask

  // Advance one clock (negedge to negedge), recording observed and expected values.
  task automatic step();
    bit pop = 0, ps = 0; int pc = 0; logic [8:0] w = '0;
    bit boundary = (phase == 0);
    drive();
    #1;
    exp_srd = '0; exp_ard = '0;
    if (boundary && en) begin
      m_decide(pop, ps, pc);
      if (pop) begin
        if (ps) begin exp_srd[pc] = 1'b1; w = sq[pc].pop_front(); end
        else    begin exp_ard[pc] = 1'b1; w = aq[pc].pop_front(); end
      end
    end
    obs_srd = sync_rd; obs_ard = async_rd;
    @(posedge clk); #1;
    exp_stb = boundary; exp_ts = 0; last_pop = 0;
    if (boundary) begin
      if (en && pop) begin m_sym = w; m_idle = 0; exp_ts = (w == TS); last_pop = 1; last_word = w; end
      else begin m_sym = KI; m_idle = 1; end
    end
    obs_sym = sym; obs_stb = stb; obs_ts = ts_o; obs_ocls = ocls; obs_och = och; obs_idle = idle;
    @(negedge clk);
    phase = (phase + 1) % SLOT;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin sq[k].delete(); aq[k].delete(); end
    smask = '0; amask = '0; en = 1'b1;
    m_cls = 0; m_ch = 0; m_hold = 0; m_last = 0; m_sym = KI; m_idle = 1;
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1; phase = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    rst_n = 1'b0;
    aq[0].push_back(9'h055); sq[1].push_back(9'h066); drive();
    #2;
    total++;
    if ({sym, stb, idle, ts_o, ocls, och, sync_rd, async_rd} !== {KI, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00}) begin
      bad++; $display("FAIL reset_values: got sym=%h stb=%b idle=%b ts=%b cls=%b ch=%b srd=%b ard=%b want sym=1bc stb=0 idle=1 ts=0 cls=0 ch=0 rd=0",
                      sym, stb, idle, ts_o, ocls, och, sync_rd, async_rd);
    end
    apply_reset();
  endtask

  task automatic test_idle();
    apply_reset();
    for (int i = 0; i < 4 * SLOT; i++) begin
      step();
      total++; if ({obs_srd, obs_ard, obs_stb} !== {exp_srd, exp_ard, exp_stb}) begin bad++;
        $display("FAIL idle_rd_stb: got %b/%b/%b want %b/%b/%b", obs_srd, obs_ard, obs_stb, exp_srd, exp_ard, exp_stb); end
      if (exp_stb) begin total++; if (obs_sym !== 9'h1BC || obs_idle !== 1'b1) begin bad++;
        $display("FAIL idle_sym: got %h idle=%b want 1bc idle=1", obs_sym, obs_idle); end end
    end
  endtask

  task automatic test_async_packet();
    logic [8:0] got[$];
    apply_reset();
    aq[0].push_back(9'h011); aq[0].push_back(9'h022); aq[0].push_back(9'h033);
    for (int i = 0; i < 14 * SLOT; i++) begin
      if (i == 12 * SLOT) aq[1].push_back(9'h0C1);
      step();
      if (last_pop) got.push_back(last_word);
      total++; if ({obs_srd, obs_ard, obs_stb} !== {exp_srd, exp_ard, exp_stb}) begin bad++;
        $display("FAIL pkt_rd_stb: got %b/%b/%b want %b/%b/%b", obs_srd, obs_ard, obs_stb, exp_srd, exp_ard, exp_stb); end
      if (exp_stb) begin total++; if ({obs_sym, obs_idle, obs_ts, obs_ocls, obs_och} !== {m_sym, m_idle, exp_ts, m_cls, CHW'(m_ch)}) begin bad++;
        $display("FAIL pkt_sym: got %h/%b/%b/%b/%0d want %h/%b/%b/%b/%0d", obs_sym, obs_idle, obs_ts, obs_ocls, obs_och, m_sym, m_idle, exp_ts, m_cls, m_ch); end end
    end
    total++;
    if (got.size() != 4 || got[0] !== 9'h011 || got[1] !== 9'h022 || got[2] !== 9'h033 || got[3] !== 9'h0C1) begin
      bad++; $display("FAIL pkt_order: got %0d words want 011 022 033 0c1", got.size()); end
  endtask

  task automatic test_preempt();
    bit seen = 0;
    apply_reset();
    for (int k = 0; k < 8; k++) aq[0].push_back(9'h040 + 9'(k));
    for (int i = 0; i < 16 * SLOT; i++) begin
      if (i == 2 * SLOT + 2) sq[1].push_back(9'h0A5);
      step();
      total++; if ({obs_srd, obs_ard, obs_stb} !== {exp_srd, exp_ard, exp_stb}) begin bad++;
        $display("FAIL pre_rd_stb: got %b/%b/%b want %b/%b/%b", obs_srd, obs_ard, obs_stb, exp_srd, exp_ard, exp_stb); end
      if (exp_stb) begin total++; if ({obs_sym, obs_idle, obs_ts, obs_ocls, obs_och} !== {m_sym, m_idle, exp_ts, m_cls, CHW'(m_ch)}) begin bad++;
        $display("FAIL pre_sym: got %h/%b/%b/%b/%0d want %h/%b/%b/%b/%0d", obs_sym, obs_idle, obs_ts, obs_ocls, obs_och, m_sym, m_idle, exp_ts, m_cls, m_ch); end end
      if (last_pop && last_word == 9'h0A5) begin
        seen = 1; total++;
        if (obs_ocls !== 1'b1 || obs_och !== 1'b1) begin bad++;
          $display("FAIL pre_owner: got cls=%b ch=%b want cls=1 ch=1", obs_ocls, obs_och); end
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL pre_seen: got no 0a5 pop want one"); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < (AH + 2) * SLOT; i++) step();
    aq[1].push_back(9'h0B1); aq[1].push_back(9'h0B2);
    for (int i = 0; i < 2 * SLOT; i++) begin
      step();
      if (exp_stb) begin total++; if ({obs_sym, obs_ocls, obs_och} !== {m_sym, m_cls, CHW'(m_ch)} || obs_och !== 1'b1) begin bad++;
        $display("FAIL rr_switch: got %h/%b/%b want %h/%b/1", obs_sym, obs_ocls, obs_och, m_sym, m_cls); end end
    end
    aq[0].push_back(9'h0A0); aq[1].push_back(9'h0B3);
    for (int i = 0; i < 3 * SLOT; i++) begin
      step();
      total++; if ({obs_srd, obs_ard} !== {exp_srd, exp_ard}) begin bad++;
        $display("FAIL rr_rd: got %b/%b want %b/%b", obs_srd, obs_ard, exp_srd, exp_ard); end
    end
  endtask

  task automatic test_timestamp();
    int pulses = 0;
    apply_reset();
    sq[0].push_back(9'h012); sq[0].push_back(TS); sq[0].push_back(9'h034);
    for (int i = 0; i < 10 * SLOT; i++) begin
      step();
      if (obs_ts) pulses++;
      total++; if (obs_ts !== exp_ts || (exp_stb && obs_sym !== m_sym)) begin bad++;
        $display("FAIL ts_flag: got ts=%b sym=%h want ts=%b sym=%h", obs_ts, obs_sym, exp_ts, m_sym); end
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL ts_count: got %0d want 1", pulses); end
  endtask

  task automatic test_enable();
    int rds = 0;
    apply_reset();
    for (int k = 0; k < 6; k++) aq[0].push_back(9'h070 + 9'(k));
    for (int i = 0; i < 8 * SLOT; i++) begin
      en = !(i >= 2 * SLOT && i < 4 * SLOT);
      step();
      if (!en) rds += $countones({obs_srd, obs_ard});
      total++; if ({obs_srd, obs_ard, obs_stb, obs_sym, obs_idle, obs_och} !== {exp_srd, exp_ard, exp_stb, m_sym, m_idle, CHW'(m_ch)}) begin bad++;
        $display("FAIL en_step: got %b/%b/%b/%h/%b/%b want %b/%b/%b/%h/%b/%0d", obs_srd, obs_ard, obs_stb, obs_sym, obs_idle, obs_och,
                 exp_srd, exp_ard, exp_stb, m_sym, m_idle, m_ch); end
    end
    en = 1'b1;
    total++; if (rds != 0) begin bad++; $display("FAIL en_pops: got %0d want 0", rds); end
  endtask

  task automatic test_reset_midslot();
    apply_reset();
    aq[0].push_back(9'h101); aq[0].push_back(9'h102); sq[0].push_back(9'h103);
    repeat (SLOT + 2) step();
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({sym, stb, idle, ts_o, ocls, och} !== {KI, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin bad++;
      $display("FAIL midslot_reset: got sym=%h stb=%b idle=%b cls=%b ch=%b want 1bc/0/1/0/0", sym, stb, idle, ocls, och); end
    @(negedge clk);
    m_cls = 0; m_ch = 0; m_hold = 0; m_last = 0; m_sym = KI; m_idle = 1;
    rst_n = 1'b1; phase = 0;
    for (int i = 0; i < 3 * SLOT; i++) begin
      step();
      total++; if ({obs_srd, obs_ard, obs_stb, obs_sym} !== {exp_srd, exp_ard, exp_stb, m_sym}) begin bad++;
        $display("FAIL midslot_resume: got %b/%b/%b/%h want %b/%b/%b/%h", obs_srd, obs_ard, obs_stb, obs_sym, exp_srd, exp_ard, exp_stb, m_sym); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600 * SLOT; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        int ch = $urandom_range(0, N - 1);
        int n = $urandom_range(1, 4);
        for (int j = 0; j < n; j++)
          if ($urandom_range(0, 3) == 0) begin if (sq[ch].size() < 6) sq[ch].push_back(9'($urandom)); end
          else if (aq[ch].size() < 12) aq[ch].push_back(9'($urandom));
      end
      smask = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
      amask = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
      if (phase == 0) en = ($urandom_range(0, 19) != 0);
      step();
      total++; if ({obs_srd, obs_ard, obs_stb} !== {exp_srd, exp_ard, exp_stb}) begin bad++;
        $display("FAIL rnd_rd_stb @%0d: got %b/%b/%b want %b/%b/%b", i, obs_srd, obs_ard, obs_stb, exp_srd, exp_ard, exp_stb); end
      if (exp_stb) begin total++; if ({obs_sym, obs_idle, obs_ts, obs_ocls, obs_och} !== {m_sym, m_idle, exp_ts, m_cls, CHW'(m_ch)}) begin bad++;
        $display("FAIL rnd_sym @%0d: got %h/%b/%b/%b/%0d want %h/%b/%b/%b/%0d", i, obs_sym, obs_idle, obs_ts, obs_ocls, obs_och, m_sym, m_idle, exp_ts, m_cls, m_ch); end end
    end
    en = 1'b1; smask = '0; amask = '0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_async_packet();
    test_preempt();
    test_round_robin();
    test_timestamp();
    test_enable();
    test_reset_midslot();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
